// File: rtl/rep_pkg.sv
// Shared widths and the run-sequencer state encoding for the repetition scheduler.
package rep_pkg;

  localparam int unsigned DEF_DATA_WIDTH             = 8;
  localparam int unsigned DEF_GROUP_SIZE             = 4;
  localparam int unsigned DEF_LOG_MAX_ITERS          = 16;
  localparam int unsigned DEF_LOG_MAX_READS_PER_ITER = 16;
  localparam int unsigned DEF_ADDR_WIDTH             = 10;
  localparam int unsigned DEF_GROUP_WIDTH            = DEF_DATA_WIDTH * DEF_GROUP_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/rep_skid_fifo.sv
// Two-entry FIFO that absorbs group-buffer read data while the detector stalls.
module rep_skid_fifo
  import rep_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_GROUP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/repetition_scheduler.sv
// Sequences a repetition_detector run: latches the configuration, configures the
// detector, re-reads the group window once per iteration and streams the groups out.
module repetition_scheduler
  import rep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int unsigned GROUP_SIZE             = DEF_GROUP_SIZE,
  parameter int unsigned LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int unsigned LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
  parameter int unsigned ADDR_WIDTH             = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  output logic                              busy,
  output logic                              done,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  input  logic [DATA_WIDTH*GROUP_SIZE-1:0]  rd_data,
  output logic                              det_configure,
  output logic [LOG_MAX_ITERS-1:0]          det_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] det_num_reads_per_iter,
  output logic [DATA_WIDTH*GROUP_SIZE-1:0]  det_data,
  output logic                              det_valid,
  input  logic                              det_avail
);

  localparam int unsigned GROUP_W = DATA_WIDTH * GROUP_SIZE;
  localparam int unsigned XFER_W  = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;

  state_t                            state;
  state_t                            state_next;
  logic [ADDR_WIDTH-1:0]             cfg_base;
  logic [LOG_MAX_ITERS-1:0]          iter_idx;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_idx;
  logic [XFER_W-1:0]                 xfer_cnt;
  logic [XFER_W-1:0]                 xfer_total;
  logic                              rd_pending;

  logic [GROUP_W-1:0]                fifo_head;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [1:0]                        fifo_count;
  logic                              pop;
  logic [2:0]                        occupancy;
  logic                              issue_ok;
  logic                              last_read;
  logic                              xfer_last;
  logic                              cfg_empty;

  assign pop       = !fifo_empty && det_avail;
  // Counting the group leaving this cycle keeps the read stream at one group per
  // cycle under full throughput without ever holding more than two in flight.
  assign occupancy = 3'(rd_pending) + 3'(fifo_count) - 3'(pop);
  assign issue_ok  = (occupancy < 3'd2) && (!fifo_full || pop);
  assign last_read = (iter_idx == det_num_iters - LOG_MAX_ITERS'(1)) &&
                     (read_idx == det_num_reads_per_iter - LOG_MAX_READS_PER_ITER'(1));
  assign xfer_last = ((xfer_cnt + XFER_W'(pop)) == xfer_total);
  assign cfg_empty = (det_num_iters == '0) || (det_num_reads_per_iter == '0);

  rep_skid_fifo #(
    .WIDTH(GROUP_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_pending),
    .pop     (pop),
    .wr_data (rd_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CONFIG;
      CONFIG:  state_next = cfg_empty ? DONE : RUN;
      RUN:     if (rd_en && last_read) state_next = DRAIN;
      DRAIN:   if (xfer_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state, read issue and FIFO head.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    det_configure = 1'b0;
    case (state)
      CONFIG: begin
        busy          = 1'b1;
        det_configure = 1'b1;
      end
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
    rd_en     = (state == RUN) && issue_ok;
    rd_addr   = rd_en ? cfg_base + ADDR_WIDTH'(read_idx) : '0;
    det_valid = !fifo_empty;
    det_data  = det_valid ? fifo_head : '0;
  end

  // Configuration latch, window/iteration counters and transfer accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_num_iters          <= '0;
      det_num_reads_per_iter <= '0;
      cfg_base               <= '0;
      xfer_total             <= '0;
      xfer_cnt               <= '0;
      iter_idx               <= '0;
      read_idx               <= '0;
      rd_pending             <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      if (state == IDLE && start) begin
        det_num_iters          <= num_iters;
        det_num_reads_per_iter <= num_reads_per_iter;
        cfg_base               <= base_addr;
        xfer_total             <= XFER_W'(num_iters) * XFER_W'(num_reads_per_iter);
        xfer_cnt               <= '0;
        iter_idx               <= '0;
        read_idx               <= '0;
      end else begin
        if (rd_en) begin
          if (read_idx == det_num_reads_per_iter - LOG_MAX_READS_PER_ITER'(1)) begin
            read_idx <= '0;
            iter_idx <= iter_idx + LOG_MAX_ITERS'(1);
          end else begin
            read_idx <= read_idx + LOG_MAX_READS_PER_ITER'(1);
          end
        end
        if (pop) xfer_cnt <= xfer_cnt + XFER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_repetition_scheduler.sv
// Directed bench for repetition_scheduler with a tagged group-buffer model.
module tb_repetition_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;
  logic [9:0]  base_addr;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        det_configure;
  logic [15:0] det_num_iters;
  logic [15:0] det_num_reads_per_iter;
  logic [31:0] det_data;
  logic        det_valid;
  logic        det_avail;

  int tests_run;
  int tests_failed;

  int cyc, n_rd, n_x, n_done, n_cfg, done_cyc, ovf, m_occ, m_pend, mseq;
  logic [9:0]  rd_addrs  [256];
  int          rd_cyc    [256];
  logic [31:0] xfer_data [256];
  int          xfer_cyc  [256];

  repetition_scheduler #(
    .DATA_WIDTH(8), .GROUP_SIZE(4), .LOG_MAX_ITERS(16),
    .LOG_MAX_READS_PER_ITER(16), .ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .base_addr(base_addr),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .det_configure(det_configure), .det_num_iters(det_num_iters),
    .det_num_reads_per_iter(det_num_reads_per_iter), .det_data(det_data),
    .det_valid(det_valid), .det_avail(det_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Group tagged with its global read sequence number so loss/duplication shows.
  function automatic logic [31:0] gdata(input int seq, input logic [9:0] a);
    logic [7:0] s;
    s = seq[7:0];
    return {s, a[7:0], s ^ 8'h5A, 6'd0, a[9:8]};
  endfunction

  function automatic logic [9:0] exp_addr(input logic [9:0] b, input int j, input int reads);
    return b + 10'(j % reads);
  endfunction

  // Group buffer with one cycle of read latency.
  initial mseq = 0;
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= gdata(mseq, rd_addr);
      mseq    <= mseq + 1;
    end
  end

  // Event recorder and independent in-flight occupancy tracker.
  initial begin
    cyc = 0; n_rd = 0; n_x = 0; n_done = 0; n_cfg = 0; done_cyc = -1;
    ovf = 0; m_occ = 0; m_pend = 0;
  end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_addrs[n_rd % 256] <= rd_addr;
      rd_cyc[n_rd % 256]   <= cyc;
      n_rd <= n_rd + 1;
    end
    if (det_valid && det_avail) begin
      xfer_data[n_x % 256] <= det_data;
      xfer_cyc[n_x % 256]  <= cyc;
      n_x <= n_x + 1;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (det_configure) n_cfg <= n_cfg + 1;
    if (rst) begin
      m_occ  <= 0;
      m_pend <= 0;
    end else begin
      if (m_pend + m_occ > 2) ovf <= ovf + 1;
      m_occ  <= m_occ + m_pend - ((det_valid && det_avail) ? 1 : 0);
      m_pend <= rd_en ? 1 : 0;
    end
  end

  // Drives one run; extra start pulses at cycle offsets e1/e2 carry bogus config.
  task automatic run_cfg(input logic [15:0] it, input logic [15:0] rd, input logic [9:0] b,
                         input bit toggle, input int e1, input int e2,
                         output int s_cyc, output int r0, output int x0,
                         output int d0, output int c0, output bit ok);
    r0 = n_rd; x0 = n_x; d0 = n_done; c0 = n_cfg; ok = 1'b0; s_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (k > 0 && n_done > d0 && k > e1 && k > e2) begin
        start = 1'b0; det_avail = 1'b1; ok = 1'b1;
        break;
      end
      if (k == 0) begin
        s_cyc = cyc; start = 1'b1;
        num_iters = it; num_reads_per_iter = rd; base_addr = b;
      end else if (k == e1 || k == e2) begin
        start = 1'b1; num_iters = 16'd7; num_reads_per_iter = 16'd7; base_addr = 10'h100;
      end else begin
        start = 1'b0;
      end
      det_avail = toggle ? (k % 2 == 0) : 1'b1;
    end
    start = 1'b0; det_avail = 1'b1;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL run_timeout: done not seen, got %0d dones, required 1", n_done - d0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, rd_en, det_configure, det_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, rd_en, det_configure, det_valid});
    end
    tests_run++;
    if ({rd_addr, det_data, det_num_iters, det_num_reads_per_iter} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h data=%h ni=%h nr=%h, required all 0",
               rd_addr, det_data, det_num_iters, det_num_reads_per_iter);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s, r0, x0, d0, c0;
    bit ok;
    run_cfg(16'd1, 16'd4, 10'h010, 1'b0, -1, -1, s, r0, x0, d0, c0, ok);
    tests_run++;
    if (n_rd - r0 !== 4) begin
      tests_failed++; $display("FAIL basic_reads: got %0d, required 4", n_rd - r0);
    end
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if (rd_addrs[(r0 + j) % 256] !== 10'h010 + 10'(j)) begin
        tests_failed++;
        $display("FAIL basic_addr[%0d]: got %h, required %h", j, rd_addrs[(r0 + j) % 256], 10'h010 + 10'(j));
      end
      tests_run++;
      if (xfer_data[(x0 + j) % 256] !== gdata(r0 + j, 10'h010 + 10'(j))) begin
        tests_failed++;
        $display("FAIL basic_data[%0d]: got %h, required %h", j, xfer_data[(x0 + j) % 256],
                 gdata(r0 + j, 10'h010 + 10'(j)));
      end
    end
    tests_run++;
    if (n_x - x0 !== 4) begin
      tests_failed++; $display("FAIL basic_xfers: got %0d, required 4", n_x - x0);
    end
    tests_run++;
    if (n_cfg - c0 !== 1) begin
      tests_failed++; $display("FAIL basic_configure: got %0d pulses, required 1", n_cfg - c0);
    end
    tests_run++;
    if (rd_cyc[r0 % 256] - s !== 2) begin
      tests_failed++; $display("FAIL basic_first_rd: got +%0d, required +2", rd_cyc[r0 % 256] - s);
    end
    tests_run++;
    if (xfer_cyc[x0 % 256] - rd_cyc[r0 % 256] !== 2) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, required 2", xfer_cyc[x0 % 256] - rd_cyc[r0 % 256]);
    end
    tests_run++;
    if (xfer_cyc[(x0 + 3) % 256] - xfer_cyc[x0 % 256] !== 3) begin
      tests_failed++;
      $display("FAIL basic_throughput: got span %0d, required 3",
               xfer_cyc[(x0 + 3) % 256] - xfer_cyc[x0 % 256]);
    end
    tests_run++;
    if (done_cyc - xfer_cyc[(x0 + 3) % 256] !== 1) begin
      tests_failed++;
      $display("FAIL basic_done: got +%0d, required +1", done_cyc - xfer_cyc[(x0 + 3) % 256]);
    end
    tests_run++;
    if ({det_num_iters, det_num_reads_per_iter} !== {16'd1, 16'd4}) begin
      tests_failed++;
      $display("FAIL basic_det_cfg: got %0d/%0d, required 1/4", det_num_iters, det_num_reads_per_iter);
    end
  endtask

  task automatic test_wrap();
    int s, r0, x0, d0, c0;
    bit ok;
    logic [9:0] exp_a [6];
    exp_a = '{10'h3FF, 10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h000};
    run_cfg(16'd3, 16'd2, 10'h3FF, 1'b0, -1, -1, s, r0, x0, d0, c0, ok);
    tests_run++;
    if (n_rd - r0 !== 6 || n_x - x0 !== 6) begin
      tests_failed++;
      $display("FAIL wrap_counts: got %0d reads %0d xfers, required 6 6", n_rd - r0, n_x - x0);
    end
    for (int j = 0; j < 6; j++) begin
      tests_run++;
      if (rd_addrs[(r0 + j) % 256] !== exp_a[j]) begin
        tests_failed++;
        $display("FAIL wrap_addr[%0d]: got %h, required %h", j, rd_addrs[(r0 + j) % 256], exp_a[j]);
      end
      tests_run++;
      if (xfer_data[(x0 + j) % 256] !== gdata(r0 + j, exp_a[j])) begin
        tests_failed++;
        $display("FAIL wrap_data[%0d]: got %h, required %h", j, xfer_data[(x0 + j) % 256],
                 gdata(r0 + j, exp_a[j]));
      end
    end
  endtask

  task automatic test_backpressure();
    int s, r0, x0, d0, c0, ovf0;
    bit ok;
    ovf0 = ovf;
    run_cfg(16'd2, 16'd4, 10'h050, 1'b1, -1, -1, s, r0, x0, d0, c0, ok);
    tests_run++;
    if (n_rd - r0 !== 8 || n_x - x0 !== 8) begin
      tests_failed++;
      $display("FAIL bp_counts: got %0d reads %0d xfers, required 8 8", n_rd - r0, n_x - x0);
    end
    for (int j = 0; j < 8; j++) begin
      tests_run++;
      if (xfer_data[(x0 + j) % 256] !== gdata(r0 + j, exp_addr(10'h050, j, 4))) begin
        tests_failed++;
        $display("FAIL bp_data[%0d]: got %h, required %h", j, xfer_data[(x0 + j) % 256],
                 gdata(r0 + j, exp_addr(10'h050, j, 4)));
      end
    end
    tests_run++;
    if (ovf - ovf0 !== 0) begin
      tests_failed++; $display("FAIL bp_occupancy: got %0d cycles above 2, required 0", ovf - ovf0);
    end
  endtask

  task automatic test_zero_iters();
    int s, r0, x0, d0, c0;
    bit ok;
    run_cfg(16'd0, 16'd4, 10'h020, 1'b0, -1, -1, s, r0, x0, d0, c0, ok);
    tests_run++;
    if (n_cfg - c0 !== 1) begin
      tests_failed++; $display("FAIL zero_configure: got %0d pulses, required 1", n_cfg - c0);
    end
    tests_run++;
    if (n_rd - r0 !== 0 || n_x - x0 !== 0) begin
      tests_failed++;
      $display("FAIL zero_activity: got %0d reads %0d xfers, required 0 0", n_rd - r0, n_x - x0);
    end
    tests_run++;
    if (done_cyc - s !== 2) begin
      tests_failed++; $display("FAIL zero_done: got +%0d, required +2", done_cyc - s);
    end
  endtask

  task automatic test_abort();
    int s, r0, x0, d0, c0;
    bit ok, hit;
    r0 = n_rd; x0 = n_x; d0 = n_done; hit = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (n_x - x0 >= 3) begin
        start = 1'b0; rst = 1'b1; hit = 1'b1;
        break;
      end
      start = (k == 0);
      if (k == 0) begin
        num_iters = 16'd2; num_reads_per_iter = 16'd4; base_addr = 10'h080;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (!hit) begin
      tests_failed++; $display("FAIL abort_reach: got %0d xfers, required 3", n_x - x0);
    end
    tests_run++;
    if ({busy, done, rd_en, det_configure, det_valid, rd_addr, det_data,
         det_num_iters, det_num_reads_per_iter} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got busy=%b valid=%b rd_en=%b data=%h ni=%h, required all 0",
               busy, det_valid, rd_en, det_data, det_num_iters);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (n_done - d0 !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d dones busy=%b, required 0 0", n_done - d0, busy);
    end
    @(posedge clk); #1;
    run_cfg(16'd1, 16'd4, 10'h020, 1'b0, -1, -1, s, r0, x0, d0, c0, ok);
    tests_run++;
    if (n_x - x0 !== 4 || n_done - d0 !== 1) begin
      tests_failed++;
      $display("FAIL abort_rerun: got %0d xfers %0d dones, required 4 1", n_x - x0, n_done - d0);
    end
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if (xfer_data[(x0 + j) % 256] !== gdata(r0 + j, 10'h020 + 10'(j))) begin
        tests_failed++;
        $display("FAIL abort_rerun_data[%0d]: got %h, required %h", j, xfer_data[(x0 + j) % 256],
                 gdata(r0 + j, 10'h020 + 10'(j)));
      end
    end
  endtask

  task automatic test_ignore_start();
    int s, r0, x0, d0, c0, r_after;
    bit ok;
    // Offsets 3 (RUN) and 8 (the DONE cycle of a 2x2 run at full rate).
    run_cfg(16'd2, 16'd2, 10'h040, 1'b0, 3, 8, s, r0, x0, d0, c0, ok);
    tests_run++;
    if (done_cyc - s !== 8) begin
      tests_failed++; $display("FAIL ign_done_cycle: got +%0d, required +8", done_cyc - s);
    end
    tests_run++;
    if ({det_num_iters, det_num_reads_per_iter} !== {16'd2, 16'd2}) begin
      tests_failed++;
      $display("FAIL ign_cfg: got %0d/%0d, required 2/2", det_num_iters, det_num_reads_per_iter);
    end
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if (rd_addrs[(r0 + j) % 256] !== exp_addr(10'h040, j, 2)) begin
        tests_failed++;
        $display("FAIL ign_addr[%0d]: got %h, required %h", j, rd_addrs[(r0 + j) % 256],
                 exp_addr(10'h040, j, 2));
      end
    end
    r_after = n_rd;
    repeat (10) @(negedge clk);
    tests_run++;
    if (n_rd - r_after !== 0 || n_cfg - c0 !== 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ign_no_rerun: got %0d reads %0d configs busy=%b, required 0 1 0",
               n_rd - r_after, n_cfg - c0, busy);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; start = 1'b0; num_iters = '0; num_reads_per_iter = '0;
    base_addr = '0; det_avail = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_iters();
    test_abort();
    test_ignore_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
